// File: rtl/axis_pkg.sv
// Shared helpers and parameter-legality checks for the axis_* stream blocks.
package axis_pkg;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned keep_w(input int unsigned width);
    return width / 8;
  endfunction

  function automatic bit width_ok(input int unsigned width);
    return (width >= 8) && ((width % 8) == 0);
  endfunction

  function automatic bit is_pow2(input int unsigned n);
    return (n != 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/axis_idle_timer.sv
// Saturating idle counter; expired stays high while the count sits at TIMEOUT.
module axis_idle_timer #(
  parameter int unsigned TIMEOUT = 8
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic en,
  input  logic clr,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != MAX_CNT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == MAX_CNT);

endmodule

// File: rtl/axis_upsizer_pack.sv
// AXI-Stream upsizer: packs RATIO narrow beats LSB-lane first into one wide beat,
// with tkeep propagation, zero-padded partial beats on tlast and optional idle flush.
module axis_upsizer_pack
  import axis_pkg::*;
#(
  parameter int unsigned S_DATA_W      = 32,
  parameter int unsigned RATIO         = 4,
  parameter int unsigned FLUSH_TIMEOUT = 0
) (
  input  logic                             aclk,
  input  logic                             aresetn,
  input  logic [S_DATA_W-1:0]              s_axis_tdata,
  input  logic [keep_w(S_DATA_W)-1:0]       s_axis_tkeep,
  input  logic                             s_axis_tlast,
  input  logic                             s_axis_tvalid,
  output logic                             s_axis_tready,
  output logic [S_DATA_W*RATIO-1:0]        m_axis_tdata,
  output logic [keep_w(S_DATA_W*RATIO)-1:0] m_axis_tkeep,
  output logic                             m_axis_tlast,
  output logic                             m_axis_tvalid,
  input  logic                             m_axis_tready
);

  localparam int unsigned M_DATA_W = S_DATA_W * RATIO;
  localparam int unsigned S_KEEP_W = keep_w(S_DATA_W);
  localparam int unsigned M_KEEP_W = keep_w(M_DATA_W);
  localparam int unsigned CNT_W    = clog2_min1(RATIO);
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(RATIO - 1);

  if (!width_ok(S_DATA_W)) begin : g_bad_width
    $error("axis_upsizer_pack: S_DATA_W must be a multiple of 8 and >= 8");
  end
  if (!is_pow2(RATIO) || (RATIO < 2) || (RATIO > 16)) begin : g_bad_ratio
    $error("axis_upsizer_pack: RATIO must be a power of 2 in 2..16");
  end

  logic [RATIO-1:0][S_DATA_W-1:0] store_data_q, store_data_d;
  logic [RATIO-1:0][S_KEEP_W-1:0] store_keep_q, store_keep_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic [M_DATA_W-1:0]            out_data_q, out_data_d;
  logic [M_KEEP_W-1:0]            out_keep_q, out_keep_d;
  logic                           out_last_q, out_last_d;
  logic                           out_valid_q, out_valid_d;

  logic accept, complete, flush;

  assign s_axis_tready = !out_valid_q || m_axis_tready;
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign complete      = accept && ((cnt_q == LAST_LANE) || s_axis_tlast);

  if (FLUSH_TIMEOUT > 0) begin : g_flush
    logic expired;

    // A flush needs a free output slot; an accepted beat always takes priority.
    assign flush = expired && s_axis_tready && !accept && (cnt_q != '0);

    axis_idle_timer #(
      .TIMEOUT (FLUSH_TIMEOUT)
    ) u_idle_timer (
      .aclk    (aclk),
      .aresetn (aresetn),
      .en      ((cnt_q != '0) && !accept),
      .clr     (accept || (cnt_q == '0) || flush),
      .expired (expired)
    );
  end else begin : g_no_flush
    assign flush = 1'b0;
  end

  always_comb begin
    store_data_d = store_data_q;
    store_keep_d = store_keep_q;
    cnt_d        = cnt_q;
    out_data_d   = out_data_q;
    out_keep_d   = out_keep_q;
    out_last_d   = out_last_q;
    out_valid_d  = out_valid_q;

    if (out_valid_q && m_axis_tready) begin
      out_valid_d = 1'b0;
    end

    if (accept) begin
      store_data_d[cnt_q] = s_axis_tdata;
      store_keep_d[cnt_q] = s_axis_tkeep;
      if (complete) begin
        // Lanes above cnt are already zero because the store clears on every emit.
        out_data_d   = store_data_d;
        out_keep_d   = store_keep_d;
        out_last_d   = s_axis_tlast;
        out_valid_d  = 1'b1;
        cnt_d        = '0;
        store_data_d = '0;
        store_keep_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (flush) begin
      out_data_d   = store_data_q;
      out_keep_d   = store_keep_q;
      out_last_d   = 1'b0;
      out_valid_d  = 1'b1;
      cnt_d        = '0;
      store_data_d = '0;
      store_keep_d = '0;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      store_data_q <= '0;
      store_keep_q <= '0;
      cnt_q        <= '0;
      out_data_q   <= '0;
      out_keep_q   <= '0;
      out_last_q   <= 1'b0;
      out_valid_q  <= 1'b0;
    end else begin
      store_data_q <= store_data_d;
      store_keep_q <= store_keep_d;
      cnt_q        <= cnt_d;
      out_data_q   <= out_data_d;
      out_keep_q   <= out_keep_d;
      out_last_q   <= out_last_d;
      out_valid_q  <= out_valid_d;
    end
  end

  assign m_axis_tdata  = out_data_q;
  assign m_axis_tkeep  = out_keep_q;
  assign m_axis_tlast  = out_last_q;
  assign m_axis_tvalid = out_valid_q;

endmodule

// File: tb/tb_axis_upsizer_pack.sv
// Bench for axis_upsizer_pack: 32x4 with idle flush, plus an 8x16 instance without flush.
module tb_axis_upsizer_pack;

  localparam int unsigned TO = 8;

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;
  logic aresetn = 1'b0;

  // Instance A: 32-bit x4, flush after TO idle cycles
  logic [31:0]  s_tdata = '0;
  logic [3:0]   s_tkeep = '0;
  logic         s_tlast = 1'b0, s_tvalid = 1'b0, s_tready;
  logic [127:0] m_tdata;
  logic [15:0]  m_tkeep;
  logic         m_tlast, m_tvalid;
  logic         m_tready = 1'b1;

  // Instance B: 8-bit x16, flush disabled
  logic [7:0]   b_s_tdata = '0;
  logic [0:0]   b_s_tkeep = '0;
  logic         b_s_tlast = 1'b0, b_s_tvalid = 1'b0, b_s_tready;
  logic [127:0] b_m_tdata;
  logic [15:0]  b_m_tkeep;
  logic         b_m_tlast, b_m_tvalid;
  logic         b_m_tready = 1'b1;

  axis_upsizer_pack #(
    .S_DATA_W      (32),
    .RATIO         (4),
    .FLUSH_TIMEOUT (TO)
  ) dut_a (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axis_tdata  (s_tdata),
    .s_axis_tkeep  (s_tkeep),
    .s_axis_tlast  (s_tlast),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tkeep  (m_tkeep),
    .m_axis_tlast  (m_tlast),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready)
  );

  axis_upsizer_pack #(
    .S_DATA_W      (8),
    .RATIO         (16),
    .FLUSH_TIMEOUT (0)
  ) dut_b (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axis_tdata  (b_s_tdata),
    .s_axis_tkeep  (b_s_tkeep),
    .s_axis_tlast  (b_s_tlast),
    .s_axis_tvalid (b_s_tvalid),
    .s_axis_tready (b_s_tready),
    .m_axis_tdata  (b_m_tdata),
    .m_axis_tkeep  (b_m_tkeep),
    .m_axis_tlast  (b_m_tlast),
    .m_axis_tvalid (b_m_tvalid),
    .m_axis_tready (b_m_tready)
  );

  int nerr = 0;
  int nchk = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: narrow beats accepted so far, and the wide beats they must produce.
  typedef struct {
    logic [127:0] d;
    logic [15:0]  k;
    logic         l;
  } wide_t;

  wide_t       expq[$];
  logic [31:0] pend_d[$];
  logic [3:0]  pend_k[$];
  bit          sb_en = 1'b0;
  bit          prev_stall = 1'b0;
  wide_t       prev_out;
  int          out_cnt = 0;

  always @(negedge aclk) begin
    if (!aresetn) begin
      pend_d.delete();
      pend_k.delete();
      expq.delete();
      prev_stall = 1'b0;
    end else if (sb_en) begin
      check("s_tready_rule", 128'(s_tready), 128'(!m_tvalid || m_tready));
      if (prev_stall) begin
        check("hold_valid", 128'(m_tvalid), 128'(1));
        check("hold_data", m_tdata, prev_out.d);
        check("hold_keep", 128'(m_tkeep), 128'(prev_out.k));
        check("hold_last", 128'(m_tlast), 128'(prev_out.l));
      end
      if (m_tvalid && m_tready) begin
        check("sb_has_expect", 128'(expq.size() > 0), 128'(1));
        if (expq.size() > 0) begin
          wide_t e;
          e = expq.pop_front();
          check("sb_data", m_tdata, e.d);
          check("sb_keep", 128'(m_tkeep), 128'(e.k));
          check("sb_last", 128'(m_tlast), 128'(e.l));
        end
        out_cnt++;
      end
      if (s_tvalid && s_tready) begin
        pend_d.push_back(s_tdata);
        pend_k.push_back(s_tkeep);
        if (s_tlast || (pend_d.size() == 4)) begin
          wide_t w;
          w.d = '0;
          w.k = '0;
          w.l = s_tlast;
          for (int i = 0; i < pend_d.size(); i++) begin
            w.d[i*32 +: 32] = pend_d[i];
            w.k[i*4 +: 4]   = pend_k[i];
          end
          expq.push_back(w);
          pend_d.delete();
          pend_k.delete();
        end
      end
      prev_stall = m_tvalid && !m_tready;
      prev_out.d = m_tdata;
      prev_out.k = m_tkeep;
      prev_out.l = m_tlast;
    end
  end

  // Output-ready pattern: 0 = always ready, 1 = toggle each cycle, 2 = random 70%
  int mt_mode = 0;
  always @(posedge aclk) begin
    #1;
    case (mt_mode)
      1:       m_tready = ~m_tready;
      2:       m_tready = ($urandom_range(0, 9) < 7);
      default: m_tready = 1'b1;
    endcase
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Present one beat and hold it until accepted (bounded wait).
  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    bit acc;
    acc      = 1'b0;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tkeep  = k;
    s_tlast  = l;
    for (int c = 0; c < 50 && !acc; c++) begin
      @(negedge aclk);
      acc = s_tready;
      tick();
    end
    if (!acc) check("accept_timeout", 128'(acc), 128'(1));
  endtask

  task automatic idle_chk(input int n, input string name);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    for (int c = 0; c < n; c++) begin
      tick();
      check(name, 128'(m_tvalid), 128'(0));
    end
  endtask

  typedef struct {
    logic [3:0][31:0] d;
    logic [3:0][3:0]  k;
    int               n;
    logic             last;
    logic [127:0]     ed;
    logic [15:0]      ek;
    logic             el;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{d: {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111},
                k: {4'hF, 4'hF, 4'hF, 4'hF}, n: 4, last: 1'b1,
                ed: 128'h44444444_33333333_22222222_11111111, ek: 16'hFFFF, el: 1'b1};
    vecs[1] = '{d: {32'h0, 32'h0, 32'hBBBB0002, 32'hAAAA0001},
                k: {4'h0, 4'h0, 4'hF, 4'hF}, n: 2, last: 1'b1,
                ed: 128'h00000000_00000000_BBBB0002_AAAA0001, ek: 16'h00FF, el: 1'b1};
    vecs[2] = '{d: {32'h0, 32'h0, 32'h0, 32'hDEADBEEF},
                k: {4'h0, 4'h0, 4'h0, 4'h3}, n: 1, last: 1'b1,
                ed: 128'h00000000_00000000_00000000_DEADBEEF, ek: 16'h0003, el: 1'b1};
    vecs[3] = '{d: {32'h0D0E0F10, 32'h090A0B0C, 32'h05060708, 32'h01020304},
                k: {4'h8, 4'h4, 4'h2, 4'h1}, n: 4, last: 1'b0,
                ed: 128'h0D0E0F10_090A0B0C_05060708_01020304, ek: 16'h8421, el: 1'b0};
    vecs[4] = '{d: {32'h0, 32'h9ABCDEF0, 32'h12345678, 32'hCAFE0000},
                k: {4'h0, 4'hF, 4'h0, 4'hF}, n: 3, last: 1'b1,
                ed: 128'h00000000_9ABCDEF0_12345678_CAFE0000, ek: 16'h0F0F, el: 1'b1};

    // Reset state
    aresetn = 1'b0;
    tick();
    tick();
    check("rst_valid", 128'(m_tvalid), 128'(0));
    check("rst_data", m_tdata, 128'(0));
    check("rst_keep", 128'(m_tkeep), 128'(0));
    check("rst_last", 128'(m_tlast), 128'(0));
    check("rst_b_valid", 128'(b_m_tvalid), 128'(0));
    aresetn = 1'b1;
    tick();
    check("rst_ready", 128'(s_tready), 128'(1));
    sb_en = 1'b1;

    // Table vectors (T1, T2 and more): 1-cycle latency, then drop after handshake
    for (int v = 0; v < 5; v++) begin
      for (int b = 0; b < vecs[v].n; b++) begin
        send_beat(vecs[v].d[b], vecs[v].k[b], vecs[v].last && (b == vecs[v].n - 1));
      end
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      check($sformatf("vec%0d_valid", v), 128'(m_tvalid), 128'(1));
      check($sformatf("vec%0d_data", v), m_tdata, vecs[v].ed);
      check($sformatf("vec%0d_keep", v), 128'(m_tkeep), 128'(vecs[v].ek));
      check($sformatf("vec%0d_last", v), 128'(m_tlast), 128'(vecs[v].el));
      tick();
      check($sformatf("vec%0d_drop", v), 128'(m_tvalid), 128'(0));
    end

    // T3: 16 continuous beats against a toggling ready
    begin
      int base;
      base    = out_cnt;
      mt_mode = 1;
      for (int i = 0; i < 16; i++) send_beat(32'h1000 + 32'(i), 4'hF, 1'b0);
      s_tvalid = 1'b0;
      mt_mode  = 0;
      repeat (4) tick();
      check("t3_wide_beats", 128'(out_cnt - base), 128'(4));
      check("t3_sb_empty", 128'(expq.size()), 128'(0));
    end

    // Random traffic; idle gaps kept below TO so the model never sees a flush
    mt_mode = 2;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        s_tvalid = 1'b0;
        repeat ($urandom_range(1, 3)) tick();
      end
      send_beat($urandom, 4'($urandom_range(0, 15)), ($urandom_range(0, 4) == 0));
    end
    send_beat($urandom, 4'hF, 1'b1);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    mt_mode  = 0;
    repeat (4) tick();
    check("rand_sb_empty", 128'(expq.size()), 128'(0));
    check("rand_pend_empty", 128'(pend_d.size()), 128'(0));

    // T4: idle flush after TO idle cycles plus the load cycle
    sb_en = 1'b0;
    begin
      int k;
      for (int b = 0; b < 3; b++) send_beat(32'h11111111 * 32'(b + 1), 4'hF, 1'b0);
      s_tvalid = 1'b0;
      k = 0;
      while (k < 20 && !m_tvalid) begin
        tick();
        k++;
      end
      check("flush_delay", 128'(k), 128'(TO + 1));
      check("flush_data", m_tdata, 128'h00000000_33333333_22222222_11111111);
      check("flush_keep", 128'(m_tkeep), 128'(16'h0FFF));
      check("flush_last", 128'(m_tlast), 128'(0));
      tick();
      check("flush_drop", 128'(m_tvalid), 128'(0));
    end
    for (int b = 0; b < 4; b++) send_beat(32'hA0A0A0A0 + 32'(b), 4'hF, (b == 3));
    s_tvalid = 1'b0;
    check("post_flush_data", m_tdata, 128'hA0A0A0A3_A0A0A0A2_A0A0A0A1_A0A0A0A0);
    check("post_flush_keep", 128'(m_tkeep), 128'(16'hFFFF));
    tick();
    // Beat on idle cycle 8 (before expiry) and on the expiry cycle itself: beat wins
    for (int gap = TO - 1; gap <= TO; gap++) begin
      for (int b = 0; b < 3; b++) send_beat(32'h11111111 * 32'(b + 1), 4'hF, 1'b0);
      idle_chk(gap, $sformatf("noflush%0d_idle", gap));
      send_beat(32'h44444444, 4'hF, 1'b1);
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      check($sformatf("noflush%0d_valid", gap), 128'(m_tvalid), 128'(1));
      check($sformatf("noflush%0d_data", gap), m_tdata,
            128'h44444444_33333333_22222222_11111111);
      check($sformatf("noflush%0d_last", gap), 128'(m_tlast), 128'(1));
      tick();
    end

    // T5: reset mid-packet discards partial lanes
    sb_en = 1'b1;
    send_beat(32'hDEAD0001, 4'hF, 1'b0);
    send_beat(32'hDEAD0002, 4'hF, 1'b0);
    s_tvalid = 1'b0;
    aresetn  = 1'b0;
    tick();
    check("t5_rst_valid", 128'(m_tvalid), 128'(0));
    check("t5_rst_data", m_tdata, 128'(0));
    check("t5_rst_keep", 128'(m_tkeep), 128'(0));
    aresetn = 1'b1;
    for (int b = 0; b < 4; b++) send_beat(32'h5A5A0000 + 32'(b), 4'hF, (b == 3));
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    check("t5_data", m_tdata, 128'h5A5A0003_5A5A0002_5A5A0001_5A5A0000);
    check("t5_last", 128'(m_tlast), 128'(1));
    repeat (3) tick();
    check("t5_sb_empty", 128'(expq.size()), 128'(0));
    sb_en = 1'b0;

    // T6: 8-bit x16 with a zero-keep lane and early tlast
    for (int i = 1; i <= 9; i++) begin
      b_s_tvalid = 1'b1;
      b_s_tdata  = 8'(i);
      b_s_tkeep  = (i == 5) ? 1'b0 : 1'b1;
      b_s_tlast  = (i == 9);
      tick();
    end
    b_s_tvalid = 1'b0;
    b_s_tlast  = 1'b0;
    check("t6_valid", 128'(b_m_tvalid), 128'(1));
    check("t6_keep", 128'(b_m_tkeep), 128'(16'h01EF));
    check("t6_data", b_m_tdata, 128'h0000_0000_0000_0009_0807_0605_0403_0201);
    check("t6_last", 128'(b_m_tlast), 128'(1));
    tick();
    for (int i = 0; i < 16; i++) begin
      b_s_tvalid = 1'b1;
      b_s_tdata  = 8'(i * 17);
      b_s_tkeep  = 1'b1;
      b_s_tlast  = 1'b0;
      check($sformatf("t6_full_ready%0d", i), 128'(b_s_tready), 128'(1));
      tick();
      if (i < 15) check($sformatf("t6_full_pending%0d", i), 128'(b_m_tvalid), 128'(0));
    end
    b_s_tvalid = 1'b0;
    check("t6_full_data", b_m_tdata, 128'hFFEEDDCC_BBAA9988_77665544_33221100);
    check("t6_full_keep", 128'(b_m_tkeep), 128'(16'hFFFF));
    check("t6_full_last", 128'(b_m_tlast), 128'(0));
    tick();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
